// File: rtl/tl_pkg.sv
// Shared types for the traffic light controller.
// Optional all-red clearance phases: define ALL_RED_EN.
package tl_pkg;

  localparam int TW = 7;

  typedef logic [TW-1:0] sec_t;
  typedef logic [2:0]    lamp_t;

  localparam lamp_t RED = 3'b100;
  localparam lamp_t YEL = 3'b010;
  localparam lamp_t GRN = 3'b001;

  typedef enum logic [2:0] {
    PG  = 3'd0,
    PY  = 3'd1,
    SG  = 3'd2,
    SY  = 3'd3
`ifdef ALL_RED_EN
    ,
    AR1 = 3'd4,
    AR2 = 3'd5
`endif
  } state_t;

  typedef struct packed {
    lamp_t p;
    lamp_t s;
  } lamps_t;

  // A zero-second phase is not allowed; it stretches to one second.
  function automatic sec_t clamp_dur(
    input sec_t d
  );
    return (d == '0) ? sec_t'(1) : d;
  endfunction

  function automatic state_t next_state(
    input state_t s
  );
    state_t n;
    n = PG;
    case (s)
`ifdef ALL_RED_EN
      PG:      n = PY;
      PY:      n = AR1;
      AR1:     n = SG;
      SG:      n = SY;
      SY:      n = AR2;
      AR2:     n = PG;
`else
      PG:      n = PY;
      PY:      n = SG;
      SG:      n = SY;
      SY:      n = PG;
`endif
      default: n = PG;
    endcase
    return n;
  endfunction

  function automatic lamps_t lamps_of(
    input state_t s
  );
    lamps_t l;
    l = '{p: RED, s: RED};
    case (s)
      PG:      l = '{p: GRN, s: RED};
      PY:      l = '{p: YEL, s: RED};
      SG:      l = '{p: RED, s: GRN};
      SY:      l = '{p: RED, s: YEL};
      default: l = '{p: RED, s: RED};
    endcase
    return l;
  endfunction

  function automatic sec_t phase_dur(
    input state_t s,
    input sec_t   tp,
    input sec_t   ts,
    input sec_t   ta
  );
    sec_t d;
    d = sec_t'(1);
    case (s)
      PG:      d = clamp_dur(tp);
      PY:      d = clamp_dur(ta);
      SG:      d = clamp_dur(ts);
      SY:      d = clamp_dur(ta);
      default: d = sec_t'(1);
    endcase
    return d;
  endfunction

endpackage

// File: rtl/tl_prescaler.sv
// Divides clk down to a one-cycle pulse per second.
// Frozen (count held) whenever en is low.
module tl_prescaler #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  assign tick = en && (count == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/traffic_light_controller.sv
// Two-road traffic light FSM with per-second countdown.
// Define ALL_RED_EN for 1 s all-red phases between greens.
module traffic_light_controller
  import tl_pkg::*;
#(
  parameter int TICK_DIV = 50000000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [TW-1:0] TpvIn,
  input  logic [TW-1:0] TsvIn,
  input  logic [TW-1:0] TaIn,
  input  logic          hold,
  output logic [2:0]    lightP,
  output logic [2:0]    lightS,
  output logic [TW-1:0] remaining,
  output logic          tick
);

  state_t state;
  state_t nxt;
  lamps_t nlamps;
  sec_t   cur_dur;
  sec_t   nxt_dur;
  logic   en;

  assign en      = !hold && (remaining != '0);
  assign nxt     = next_state(state);
  assign nlamps  = lamps_of(nxt);
  assign cur_dur = phase_dur(state, TpvIn, TsvIn, TaIn);
  assign nxt_dur = phase_dur(nxt, TpvIn, TsvIn, TaIn);

  tl_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_presc (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .tick  (tick)
  );

  // remaining==0 only right after reset: load the current phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= PG;
      remaining <= '0;
      lightP    <= GRN;
      lightS    <= RED;
    end else if (remaining == '0) begin
      remaining <= cur_dur;
    end else if (tick) begin
      if (remaining == sec_t'(1)) begin
        state     <= nxt;
        remaining <= nxt_dur;
        lightP    <= nlamps.p;
        lightS    <= nlamps.s;
      end else begin
        remaining <= remaining - sec_t'(1);
      end
    end
  end

endmodule
